// File: rtl/uart_bus_bridge.sv
// Purpose: parse UART command frames into single femto-bus transactions and queue the reply bytes.
// Latency: last frame byte -> req next cycle; resp/fault -> status byte next cycle; read bytes follow back-to-back.
// Backpressure: tx_full stalls the reply on the current byte; rx bytes outside IDLE/ADDR/WDATA are dropped.

`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_1B
`define BUS_ACC_1B 2'd0
`endif
`ifndef BUS_ACC_2B
`define BUS_ACC_2B 2'd1
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif

module uart_bus_bridge #(
  parameter int AW            = 32,
  parameter int BUS_TIMEOUT   = 1023,
  parameter int FRAME_TIMEOUT = 65535
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_data,
  input  logic                      tx_full,
  output logic                      tx_req,
  output logic [7:0]                tx_data,
  output logic [AW-1:0]             addr,
  output logic                      w_rb,
  output logic [`BUS_ACC_WIDTH-1:0] acc,
  output logic [`BUS_WIDTH-1:0]     wdata,
  output logic                      req,
  input  logic [`BUS_WIDTH-1:0]     rdata,
  input  logic                      resp,
  input  logic                      fault,
  output logic                      busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_REQ, S_WAIT, S_REPLY
  } state_t;

  localparam logic [7:0]  ST_OK      = 8'h00;
  localparam logic [7:0]  ST_FAULT   = 8'hFF;
  localparam logic [7:0]  ST_TIMEOUT = 8'hFD;
  localparam logic [7:0]  ST_BADCMD  = 8'hEE;
  localparam logic [15:0] BUS_LIMIT  = 16'(BUS_TIMEOUT);
  localparam logic [15:0] FRAME_LAST = 16'(FRAME_TIMEOUT - 1);

  state_t                    state, state_nxt;
  logic [1:0]                cnt;        // byte index inside the address or data field
  logic [15:0]               frame_cnt;  // idle cycles since the last accepted frame byte
  logic [15:0]               wait_cnt;   // cycles spent waiting for resp
  logic [7:0]                status;
  logic [2:0]                tx_idx;     // reply byte being offered (0 = status)
  logic [2:0]                tx_last;    // index of the final reply byte
  logic [31:0]               addr_q;
  logic [31:0]               wdata_q;
  logic [31:0]               rdata_q;
  logic                      w_rb_q;
  logic [`BUS_ACC_WIDTH-1:0] acc_q;
  logic [1:0]                n_last;     // data byte count minus one for the latched size
  logic                      cmd_ok;
  logic                      frame_expire;
  logic                      bus_expire;
  logic [7:0]                tx_byte;

  assign addr  = addr_q[AW-1:0];
  assign wdata = wdata_q;
  assign w_rb  = w_rb_q;
  assign acc   = acc_q;

  assign cmd_ok       = (rx_data[6:2] == 5'd0) && (rx_data[1:0] != 2'd3);
  assign frame_expire = (frame_cnt == FRAME_LAST);
  assign bus_expire   = (wait_cnt == BUS_LIMIT);

  // Map the latched access size to the number of data bytes it carries.
  always_comb begin
    n_last = 2'd3;
    if (acc_q == `BUS_ACC_1B)      n_last = 2'd0;
    else if (acc_q == `BUS_ACC_2B) n_last = 2'd1;
  end

  // Select the reply byte: status first, then read data LSB first.
  always_comb begin
    tx_byte = status;
    case (tx_idx)
      3'd1:    tx_byte = rdata_q[7:0];
      3'd2:    tx_byte = rdata_q[15:8];
      3'd3:    tx_byte = rdata_q[23:16];
      3'd4:    tx_byte = rdata_q[31:24];
      default: tx_byte = status;
    endcase
  end

  // State register; async reset also withdraws any req in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and strobe outputs.
  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    tx_req    = 1'b0;
    tx_data   = 8'h00;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (rx_valid) state_nxt = cmd_ok ? S_ADDR : S_REPLY;
      end
      S_ADDR: begin
        if (rx_valid) begin
          if (cnt == 2'd3) state_nxt = w_rb_q ? S_WDATA : S_REQ;
        end else if (frame_expire) begin
          state_nxt = S_IDLE;
        end
      end
      S_WDATA: begin
        if (rx_valid) begin
          if (cnt == n_last) state_nxt = S_REQ;
        end else if (frame_expire) begin
          state_nxt = S_IDLE;
        end
      end
      S_REQ: begin
        req       = 1'b1;
        state_nxt = fault ? S_REPLY : S_WAIT;
      end
      S_WAIT: begin
        if (resp || bus_expire) state_nxt = S_REPLY;
      end
      S_REPLY: begin
        if (!tx_full) begin
          tx_req  = 1'b1;
          tx_data = tx_byte;
          if (tx_idx == tx_last) state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Frame assembly, bus outcome capture and reply sequencing.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt       <= 2'd0;
      frame_cnt <= 16'd0;
      wait_cnt  <= 16'd0;
      status    <= 8'h00;
      tx_idx    <= 3'd0;
      tx_last   <= 3'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      rdata_q   <= 32'd0;
      w_rb_q    <= 1'b0;
      acc_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rx_valid) begin
            cnt       <= 2'd0;
            frame_cnt <= 16'd0;
            tx_idx    <= 3'd0;
            if (cmd_ok) begin
              w_rb_q  <= rx_data[7];
              addr_q  <= 32'd0;
              wdata_q <= 32'd0;  // unused upper bytes of short writes stay zero
              case (rx_data[1:0])
                2'd0:    acc_q <= `BUS_ACC_1B;
                2'd1:    acc_q <= `BUS_ACC_2B;
                default: acc_q <= `BUS_ACC_4B;
              endcase
            end else begin
              status  <= ST_BADCMD;
              tx_last <= 3'd0;
            end
          end
        end
        S_ADDR: begin
          if (rx_valid) begin
            addr_q[{cnt, 3'b000} +: 8] <= rx_data;
            cnt       <= cnt + 2'd1;  // wraps to 0 ready for the data field
            frame_cnt <= 16'd0;
          end else begin
            frame_cnt <= frame_cnt + 16'd1;
          end
        end
        S_WDATA: begin
          if (rx_valid) begin
            wdata_q[{cnt, 3'b000} +: 8] <= rx_data;
            cnt       <= cnt + 2'd1;
            frame_cnt <= 16'd0;
          end else begin
            frame_cnt <= frame_cnt + 16'd1;
          end
        end
        S_REQ: begin
          wait_cnt <= 16'd0;
          tx_idx   <= 3'd0;
          if (fault) begin
            status  <= ST_FAULT;
            tx_last <= 3'd0;
          end
        end
        S_WAIT: begin
          tx_idx <= 3'd0;
          if (resp) begin
            status  <= ST_OK;
            rdata_q <= rdata;
            tx_last <= w_rb_q ? 3'd0 : ({1'b0, n_last} + 3'd1);
          end else if (bus_expire) begin
            status  <= ST_TIMEOUT;
            tx_last <= 3'd0;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        S_REPLY: begin
          if (!tx_full) tx_idx <= (tx_idx == tx_last) ? 3'd0 : tx_idx + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/uart_bus_bridge.md
# uart_bus_bridge

Host-side debug initiator that sits behind the UART byte streams: it parses command frames arriving from the UART receiver and turns them into single transactions on the femto system bus, where it acts as an initiator. It then returns status and read data through the UART transmit queue. It is the initiator counterpart of the bus-slave UART controller: it drives `req`, `addr`, `w_rb`, `acc` and `wdata`, and samples `resp`, `fault` and `rdata`.

## Interface
- AW, 32: bus address width. The frame always carries 4 address bytes; bits above AW are discarded.
- BUS_TIMEOUT, 1023: cycles to wait for `resp` after `req` before reporting a timeout; 16-bit counter.
- FRAME_TIMEOUT, 65535: idle cycles allowed between bytes of one frame before the partial frame is dropped; 16-bit counter.

- clk  in  1  system clock; single clock domain.
- rstn  in  1  reset, asynchronous, active-low.
- rx_valid  in  1  one-cycle strobe; a received byte is on `rx_data`.
- rx_data  in  8  received byte.
- tx_full  in  1  transmit queue full.
- tx_req  out  1  one-cycle write strobe into the transmit queue.
- tx_data  out  8  byte to enqueue; valid while `tx_req` is high.
- addr  out  AW  bus address.
- w_rb  out  1  1 = write, 0 = read.
- acc  out  `BUS_ACC_WIDTH`  access size: `BUS_ACC_1B`, `BUS_ACC_2B` or `BUS_ACC_4B`.
- wdata  out  `BUS_WIDTH`  write data.
- req  out  1  one-cycle request strobe.
- rdata  in  `BUS_WIDTH`  read data; valid in the `resp` cycle.
- resp  in  1  transaction completed.
- fault  in  1  transaction rejected; asserted combinationally in the `req` cycle.
- busy  out  1  high in every state except IDLE.

## Operation
- **Frame format.** CMD, then A0..A3 (LSB first), then for writes D0..D(N-1) (LSB first).
- **CMD byte fields.**
  - bit7: w_rb.
  - bits[1:0]: size. 0 selects 1B (N=1), 1 selects 2B (N=2), 2 selects 4B (N=4). 3 is illegal.
  - bits[6:2]: must be 0.
- **Reply format.**
  - Status byte first: 0x00 OK, 0xFF bus fault, 0xFD bus timeout, 0xEE bad command.
  - On a read with OK status, N rdata bytes follow, LSB first.
- **States.**
  - IDLE: wait for the CMD byte.
  - ADDR: collect A0..A3.
  - WDATA: collect write bytes; reads skip this state.
  - REQ: issue `req` for one cycle.
  - WAIT: wait for `resp` or timeout.
  - REPLY: emit the status byte and any read data.
  - REPLY then returns to IDLE.
- **Bad command.** An illegal CMD moves directly to REPLY with status 0xEE. The next received byte is parsed as a new CMD.
- **Address.** `addr` bits and `wdata` are assembled from the bytes in order. For 1B/2B writes, the unused `wdata` bytes are 0.
- **Alignment.** The bridge does not check alignment; the slave reports a misaligned or invalid access through `fault`.
- **Bus signal stability.** `addr`, `w_rb`, `acc` and `wdata` are stable from the REQ cycle until the cycle after `resp`, `fault` or timeout.
- **Read capture.** `rdata` is captured in the `resp` cycle.
- **Outcomes.**
  - `fault` in the REQ cycle gives status 0xFF; `resp` is not waited for.
  - A WAIT count reaching BUS_TIMEOUT with no `resp` gives status 0xFD.
  - A `resp` arriving after a timeout is ignored.
- **Transmit.** `tx_req` is asserted only in cycles where `tx_full` is low. At most one byte per cycle. When `tx_full` is high, the bridge holds the current byte and its index.
- **Frame timeout.** In ADDR or WDATA, FRAME_TIMEOUT consecutive cycles without `rx_valid` return the bridge to IDLE silently, with no reply. The counter clears on every accepted byte.
- **Dropped bytes.** `rx_valid` in REQ, WAIT or REPLY is dropped.
- **Reset values** (asynchronous, including mid-operation):
  - state IDLE; `req`, `tx_req`, `busy`, `w_rb` = 0;
  - `addr`, `wdata`, `acc`, `tx_data` = 0;
  - all counters 0.
  - A `req` in flight is withdrawn immediately.

## Timing
- Last frame byte (`rx_valid` in cycle T) -> `req` high in cycle T+1, for exactly one cycle.
- `fault` in T+1 -> status `tx_req` in T+2, if `tx_full` is low.
- `resp` in cycle R -> status `tx_req` in R+1, then read bytes in R+2.. with no gaps while `tx_full` is low.
- Bad CMD in T -> `tx_req` with 0xEE in T+1.
- Last reply byte in cycle E -> IDLE in E+1. A CMD arriving in cycle E+1 is accepted.
- Timeout: the WAIT counter starts at 0 in the cycle after `req`. Status 0xFD goes out in the cycle after the counter reaches BUS_TIMEOUT.
- `busy` rises in the cycle after the CMD is accepted and falls in the cycle after the last reply byte.

## Test plan
- Write 1B: bytes 0x80,0x00,0x00,0x01,0x00,0x5A -> one `req` with `addr`=0x00010000, `w_rb`=1, `acc`=`BUS_ACC_1B`, `wdata`=0x0000005A. Slave `resp` next cycle -> single reply byte 0x00.
- Read 4B: 0x02,0x10,0x00,0x00,0x00; slave returns `rdata`=0xDEADBEEF -> reply 0x00,0xEF,0xBE,0xAD,0xDE. Hold `tx_full` high for 3 cycles mid-reply -> bytes neither lost nor repeated.
- Fault: 0x80,0x01,0,0,0,0x11 with `fault` in the `req` cycle -> reply 0xFF; no second `req`.
- Timeout with BUS_TIMEOUT=8: 0x00,0,0,0,0 with no `resp` -> 0xFD after 8 wait cycles. A late `resp` is ignored and `busy` returns to 0.
- Bad CMD 0x03 -> 0xEE. Then a partial frame 0x00,0x12 followed by silence longer than FRAME_TIMEOUT -> no `req`, no reply, back in IDLE. A following valid read then completes normally.
- Async reset asserted in WAIT -> `req`/`busy`/`tx_req` = 0 immediately. After release, the next valid frame completes normally.
